// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parameterised serial sequence detector.
// Optional match counter is enabled by defining SEQ_DETECTOR_MATCH_CNT_EN.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      DETECT = 2'd2
   } state_t;

   localparam int unsigned MIN_LEN = 2;

   // Clamp a requested pattern length into MIN_LEN..max_len.
   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned max_len);
      if (len < MIN_LEN) return MIN_LEN;
      if (len > max_len) return max_len;
      return len;
   endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register and fill counter for the sequence detector.
// Macro SEQ_DETECTOR_MATCH_CNT_EN does not affect this block.
module seq_det_hist
   import seq_det_pkg::*;
#(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_all,
   input  logic               clr_fill,
   input  logic               shift,
   input  logic               inc,
   input  logic               din,
   output logic [MAX_LEN-1:0] history,
   output logic [LEN_W-1:0]   fill
);

   // Newest bit enters at bit 0; clr_all wipes both history and fill.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         history <= '0;
         fill    <= '0;
      end else if (clr_all) begin
         history <= '0;
         fill    <= '0;
      end else begin
         if (shift)
            history <= {history[MAX_LEN-2:0], din};
         if (clr_fill)
            fill <= '0;
         else if (inc)
            fill <= fill + LEN_W'(1);
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with runtime-loadable pattern,
// length and overlap mode. Define SEQ_DETECTOR_MATCH_CNT_EN to include a
// saturating match counter; otherwise match_cnt is tied to zero.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   input  logic                           in,
   input  logic                           cfg_load,
   input  logic [MAX_LEN-1:0]             cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
   input  logic                           cfg_overlap,
   output logic                           match,
   output logic                           busy,
   output logic [CNT_W-1:0]               match_cnt
);

   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

   state_t               state, state_nxt;
   logic [MAX_LEN-1:0]   pat;
   logic [LEN_W-1:0]     len;
   logic                 ovl;
   logic [MAX_LEN-1:0]   history;
   logic [LEN_W-1:0]     fill;
   logic [MAX_LEN-1:0]   hist_next_c;
   logic [MAX_LEN-1:0]   mask_c;
   logic                 hit_c;
   logic                 match_nxt;
   logic                 clr_all, clr_fill, shift, inc;

   seq_det_hist #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_hist (
      .clk      (clk),
      .rst      (rst),
      .clr_all  (clr_all),
      .clr_fill (clr_fill),
      .shift    (shift),
      .inc      (inc),
      .din      (in),
      .history  (history),
      .fill     (fill)
   );

   // Compare the history as it will look after this bit shifts in.
   always_comb begin
      hist_next_c = {history[MAX_LEN-2:0], in};
      mask_c      = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++)
         mask_c[i] = (i < 32'(len));
      hit_c = (((hist_next_c ^ pat) & mask_c) == '0);
   end

   // Next-state, history control and match decision.
   always_comb begin
      state_nxt = state;
      match_nxt = 1'b0;
      clr_all   = 1'b0;
      clr_fill  = 1'b0;
      shift     = 1'b0;
      inc       = 1'b0;
      if (cfg_load) begin
         clr_all   = 1'b1;
         state_nxt = FILL;
      end else if (in_valid) begin
         unique case (state)
            FILL: begin
               shift = 1'b1;
               inc   = 1'b1;
               if (fill + LEN_W'(1) == len) begin
                  state_nxt = DETECT;
                  match_nxt = hit_c;
                  if (hit_c && !ovl) begin
                     clr_fill  = 1'b1;
                     state_nxt = FILL;
                  end
               end
            end
            DETECT: begin
               shift     = 1'b1;
               match_nxt = hit_c;
               if (hit_c && !ovl) begin
                  clr_fill  = 1'b1;
                  state_nxt = FILL;
               end
            end
            default: ;
         endcase
      end
   end

   // State, configuration and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         match <= 1'b0;
         busy  <= 1'b0;
         pat   <= '0;
         len   <= LEN_W'(MIN_LEN);
         ovl   <= 1'b0;
      end else begin
         state <= state_nxt;
         match <= match_nxt;
         busy  <= (state_nxt != IDLE);
         if (cfg_load) begin
            pat <= cfg_pattern;
            len <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            ovl <= cfg_overlap;
         end
      end
   end

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt;

   // Saturating count of match pulses; cfg_load leaves it alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (match_nxt && (cnt != '1))
         cnt <= cnt + CNT_W'(1);
   end

   assign match_cnt = cnt;
`else
   assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param; counter checks depend on
// SEQ_DETECTOR_MATCH_CNT_EN.
module tb_seq_detector_param;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               match;
   logic               busy;
   logic [CNT_W-1:0]   match_cnt;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic sb[$];

   seq_detector_param #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in          (in),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .match       (match),
      .busy        (busy),
      .match_cnt   (match_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one expected match value per driven cycle.
   always @(posedge clk) begin
      logic e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("match", 32'(match), 32'(e));
      end else begin
         check("match_idle", 32'(match), 32'd0);
      end
   end

   task automatic step(input logic load, input logic v, input logic b, input logic e);
      @(negedge clk);
      cfg_load = load;
      in_valid = v;
      in       = b;
      sb.push_back(e);
   endtask

   task automatic load_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                           input logic o);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = o;
      step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Feed n bits MSB first with matching per-bit expectations.
   task automatic feed(input logic [31:0] bits, input int n, input logic [31:0] exps);
      for (int i = n - 1; i >= 0; i--)
         step(1'b0, 1'b1, bits[i], exps[i]);
   endtask

   task automatic settle();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
   endtask

   task automatic check_cnt(input string name, input int exp);
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
      check(name, 32'(match_cnt), 32'(exp));
`else
      check(name, 32'(match_cnt), 32'd0);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      cfg_load = 1'b0;
      #1;
      check("rst_match", 32'(match), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cnt", 32'(match_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst         = 1'b0;
      in_valid    = 1'b0;
      in          = 1'b0;
      cfg_load    = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      #2;
      check("init_match", 32'(match), 32'd0);
      check("init_busy", 32'(busy), 32'd0);
      check("init_cnt", 32'(match_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Overlap: 1001001 against 1001
      load_cfg(8'b0000_1001, 4'd4, 1'b1);
      feed(32'b1001001, 7, 32'b0001001);
      settle();
      check("ovl_busy", 32'(busy), 32'd1);
      check_cnt("ovl_cnt", 2);
      load_cfg(8'b0000_1001, 4'd4, 1'b1);
      settle();
      check_cnt("cnt_kept_on_load", 2);

      // Non-overlap: same stream, single match
      do_reset();
      load_cfg(8'b0000_1001, 4'd4, 1'b0);
      feed(32'b1001001, 7, 32'b0001000);
      settle();
      check_cnt("novl_cnt", 1);

      // Gaps: invalid cycles carry a 0 that must be ignored
      do_reset();
      load_cfg(8'b0000_0101, 4'd3, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      settle();

      // Reconfiguration mid-stream; bit on the load cycle is dropped
      load_cfg(8'b0000_1001, 4'd4, 1'b0);
      feed(32'b100, 3, 32'b000);
      cfg_pattern = 8'b0000_0011;
      cfg_len     = 4'd2;
      cfg_overlap = 1'b0;
      step(1'b1, 1'b1, 1'b1, 1'b0);
      feed(32'b11, 2, 32'b01);
      settle();
      check("reconf_busy", 32'(busy), 32'd1);

      // Clamp low: len 0 behaves as 2
      load_cfg(8'b0000_0011, 4'd0, 1'b0);
      feed(32'b011, 3, 32'b001);
      settle();

      // Clamp high: len 9 behaves as 8; ends with match high
      load_cfg(8'hA5, 4'd9, 1'b0);
      feed(32'b1_1010_0101, 9, 32'b0_0000_0001);

      // Reset while match is high, then stream without reload
      do_reset();
      feed(32'b1100, 4, 32'b0000);
      settle();
      check("post_rst_busy", 32'(busy), 32'd0);

      // Saturation: five overlapping 11 matches
      load_cfg(8'b0000_0011, 4'd2, 1'b1);
      feed(32'b111111, 6, 32'b011111);
      settle();
      check_cnt("sat_cnt", 3);

      repeat (2) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits; legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 16: match-counter width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1: qualifies in; the serial bit is accepted only when high.
REQ-006 SHALL have port in  input  1: serial data bit.
REQ-007 SHALL have port cfg_load  input  1: one-cycle pulse that latches cfg_pattern, cfg_len and cfg_overlap.
REQ-008 SHALL have port cfg_pattern  input  MAX_LEN: target pattern; bit [len-1] is the first bit expected, bit [0] the last.
REQ-009 SHALL have port cfg_len  input  $clog2(MAX_LEN+1): pattern length.
REQ-010 SHALL have port cfg_overlap  input  1: 1 = overlapping matches allowed; 0 = history restarts after each match.
REQ-011 SHALL have port match  output  1: registered one-cycle match pulse.
REQ-012 SHALL have port busy  output  1: high while the detector is in FILL or DETECT.
REQ-013 SHALL have port match_cnt  output  CNT_W: saturating match count (present only with the macro, see REQ-029).

Function
REQ-014 SHALL implement FSM states IDLE, FILL and DETECT.
REQ-015 SHALL leave IDLE for FILL on cfg_load; in IDLE, accepted bits are ignored and match stays 0.
REQ-016 SHALL, in FILL, shift each accepted bit into a history register and increment the fill count; it SHALL enter DETECT on the accept that brings fill to len.
REQ-017 SHALL, in DETECT, assert match at the clock edge at which the accepted bit completes history[len-1:0] == pattern[len-1:0] — the same edge that shifts that bit in; match is therefore high for exactly the following cycle.
REQ-018 SHALL evaluate the completing match in the FILL-to-DETECT transition cycle as well, so the first len bits can match.
REQ-019 SHALL, with overlap=0 after a match, clear the fill count and return to FILL; with overlap=1, remain in DETECT.
REQ-020 SHALL hold all state unchanged and drive match=0 in cycles where in_valid=0.
REQ-021 SHALL clamp cfg_len below 2 to 2 and above MAX_LEN to MAX_LEN at latch time.
REQ-022 SHALL, on cfg_load in any state, latch new configuration, clear history and fill count, go to FILL and drive match=0 that cycle; a bit accepted in the same cycle is discarded.
REQ-023 SHALL latch configuration only on cfg_load; cfg_* changes at other times have no effect.
REQ-024 SHALL drive busy = (state != IDLE).

Reset
REQ-025 SHALL, on rst low, asynchronously force state=IDLE, match=0, history=0, fill=0, latched pattern=0, len=2, overlap=0 and match_cnt=0.
REQ-026 SHALL release reset synchronously to clk; the first edge with rst high is a normal cycle.
REQ-027 SHALL, on reset mid-stream, lose any partial match; detection resumes only after a new cfg_load.

Configuration
REQ-028 SHALL compile in the match counter only when macro SEQ_DETECTOR_MATCH_CNT_EN is defined.
REQ-029 SHALL, with the macro defined, increment match_cnt on each match, saturate at all-ones, and leave it unaffected by cfg_load; without the macro, match_cnt SHALL be a constant 0 and SHALL contain no counter flops.

Structure
REQ-030 SHALL place the state enum (IDLE/FILL/DETECT), the MIN_LEN=2 constant and the length-clamp function in shared package seq_det_pkg.
REQ-031 SHALL implement the history shift register and fill counter in sub-module seq_det_hist, instantiated once; the FSM, compare and output registers stay in the top module.

Verification
REQ-032 SHALL verify overlap: load pattern 1001, len 4, overlap=1, feed 1001001 -> match pulses after bit 4 and bit 7; match_cnt=2.
REQ-033 SHALL verify non-overlap: same stream with overlap=0 -> a single match after bit 4; match_cnt=1.
REQ-034 SHALL verify gaps: pattern 101, len 3, stream 1,(valid=0 x3),0,1 -> one match after the final 1, and no pulse during the gap cycles.
REQ-035 SHALL verify reconfiguration: cfg_load of 11 (len 2) after 100 of a 1001 stream, then feed 11 -> no 1001 match; match after the second 1.
REQ-036 SHALL verify reset and clamp: rst low mid-pattern -> match=0, busy=0, match_cnt=0 immediately; cfg_len=0 behaves as len 2, cfg_len=MAX_LEN+1 behaves as MAX_LEN.
REQ-037 SHALL verify saturation: with the macro defined and CNT_W=2, five matches -> match_cnt=3.
